// File: rtl/from_serial.sv
// Deserialiser: rebuilds NO_CH words of BW_OUT bits from BW_IN-bit slices, LS slice first.
// Optional FROM_SERIAL_SYNC_EN adds sync_in (slice-0 marker) and err (realignment pulse).
module from_serial #(
  parameter int NO_CH  = 64,
  parameter int BW_IN  = 4,
  parameter int BW_OUT = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          vld_in,
  input  logic [NO_CH-1:0][BW_IN-1:0]   data_in,
`ifdef FROM_SERIAL_SYNC_EN
  input  logic                          sync_in,
  output logic                          err,
`endif
  output logic                          vld_out,
  output logic [NO_CH-1:0][BW_OUT-1:0]  data_out
);

  // Handshake: vld_in qualifies data_in (and sync_in) for exactly one cycle; there is
  // no ready in either direction, so vld_out is a one-cycle pulse the consumer must take.
  localparam int SER_CYC = BW_OUT / BW_IN;
  localparam int CNT_W   = (SER_CYC > 1) ? $clog2(SER_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SER_CYC - 1);

  logic [CNT_W-1:0]             cnt;
  logic [CNT_W-1:0]             slice_idx;
  logic                         word_done;
  logic [NO_CH-1:0][BW_OUT-1:0] full_word;

`ifdef FROM_SERIAL_SYNC_EN
  // A sync mark off slice 0 drops the partial word and restarts at slice 0.
  logic realign;
  assign realign   = vld_in && sync_in && (cnt != '0);
  assign slice_idx = realign ? '0 : cnt;
`else
  assign slice_idx = cnt;
`endif

  assign word_done = vld_in && (slice_idx == LAST);

  generate
    if (SER_CYC == 1) begin : g_single
      assign full_word = data_in;
    end else begin : g_acc
      // Holds the slices received so far in its top bits; each new slice enters at
      // the MSB end so slice k ends up at bits [k*BW_IN +: BW_IN] of the final word.
      logic [NO_CH-1:0][BW_OUT-BW_IN-1:0] acc;

      for (genvar ch = 0; ch < NO_CH; ch++) begin : g_ch
        assign full_word[ch] = {data_in[ch], acc[ch]};
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          acc <= '0;
        end else if (vld_in) begin
          for (int ch = 0; ch < NO_CH; ch++) begin
            acc[ch] <= full_word[ch][BW_OUT-1:BW_IN];
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      vld_out  <= 1'b0;
      data_out <= '0;
`ifdef FROM_SERIAL_SYNC_EN
      err      <= 1'b0;
`endif
    end else begin
      vld_out <= word_done;
      if (word_done) begin
        data_out <= full_word;
      end
      if (vld_in) begin
        cnt <= word_done ? '0 : slice_idx + 1'b1;
      end
`ifdef FROM_SERIAL_SYNC_EN
      err <= realign;
`endif
    end
  end

endmodule

// File: tb/tb_from_serial.sv
// Randomised scoreboard bench for from_serial (main 2x4->16 instance plus a 16->16 instance).
module tb_from_serial;
  localparam int NO_CH  = 2;
  localparam int BW_IN  = 4;
  localparam int BW_OUT = 16;
  localparam int S      = BW_OUT / BW_IN;
  localparam int W      = NO_CH * BW_OUT;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic                         vld_in = 1'b0;
  logic [NO_CH-1:0][BW_IN-1:0]  data_in = '0;
  logic                         sync_in = 1'b0;
  logic                         vld_out;
  logic [NO_CH-1:0][BW_OUT-1:0] data_out;

  logic                         vld_d = 1'b0;
  logic [NO_CH-1:0][BW_OUT-1:0] din_d = '0;
  logic                         vout_d;
  logic [NO_CH-1:0][BW_OUT-1:0] dout_d;

`ifdef FROM_SERIAL_SYNC_EN
  logic err;
  logic err_d;
  logic err_d_seen = 1'b0;
`endif

  from_serial #(.NO_CH(NO_CH), .BW_IN(BW_IN), .BW_OUT(BW_OUT)) dut (
    .clk(clk), .rst(rst), .vld_in(vld_in), .data_in(data_in),
`ifdef FROM_SERIAL_SYNC_EN
    .sync_in(sync_in), .err(err),
`endif
    .vld_out(vld_out), .data_out(data_out)
  );

  from_serial #(.NO_CH(NO_CH), .BW_IN(16), .BW_OUT(16)) dut_deg (
    .clk(clk), .rst(rst), .vld_in(vld_d), .data_in(din_d),
`ifdef FROM_SERIAL_SYNC_EN
    .sync_in(1'b1), .err(err_d),
`endif
    .vld_out(vout_d), .data_out(dout_d)
  );

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  // Reference model: count of slices collected and the partial word per channel.
  int               nslices = 0;
  logic [BW_OUT-1:0] part [NO_CH];
  logic [W-1:0]     last_word = '0;

  logic [W-1:0] exp_q[$];
  int           exp_e_q[$];
  int           err_e_q[$];
  logic [W-1:0] exp_d_q[$];
  int           exp_de_q[$];

  task automatic check_eq(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic model(input logic [NO_CH*BW_IN-1:0] d, input logic s);
    logic [W-1:0] w;
`ifdef FROM_SERIAL_SYNC_EN
    if (s && nslices != 0) begin
      nslices = 0;
      err_e_q.push_back(edge_n);
    end
`else
    if (s) begin end
`endif
    for (int ch = 0; ch < NO_CH; ch++) begin
      if (nslices == 0) part[ch] = '0;
      part[ch] = part[ch] | (BW_OUT'(d[ch*BW_IN +: BW_IN]) << (nslices * BW_IN));
    end
    nslices++;
    if (nslices == S) begin
      for (int ch = 0; ch < NO_CH; ch++) w[ch*BW_OUT +: BW_OUT] = part[ch];
      exp_q.push_back(w);
      exp_e_q.push_back(edge_n);
      last_word = w;
      nslices = 0;
    end
  endtask

  // Inputs change 1 time unit after a rising edge; the model sees a slice at the edge that samples it.
  task automatic step(input logic v, input logic [NO_CH*BW_IN-1:0] d, input logic s);
    vld_in  = v;
    data_in = d;
    sync_in = s;
    @(posedge clk);
    edge_n++;
    if (v) model(d, s);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, NO_CH*BW_IN'($urandom), 1'($urandom_range(0, 1)));
  endtask

  task automatic send_word(input logic [W-1:0] w, input int gap, input logic sync_first);
    logic [NO_CH*BW_IN-1:0] d;
    for (int k = 0; k < S; k++) begin
      for (int ch = 0; ch < NO_CH; ch++) d[ch*BW_IN +: BW_IN] = w[ch*BW_OUT + k*BW_IN +: BW_IN];
      step(1'b1, d, sync_first && (k == 0));
      if (k != S - 1) idle(gap);
    end
  endtask

  task automatic step_d(input logic v, input logic [W-1:0] d);
    vld_in = 1'b0;
    vld_d  = v;
    din_d  = d;
    @(posedge clk);
    edge_n++;
    if (v) begin
      exp_d_q.push_back(d);
      exp_de_q.push_back(edge_n);
    end
    #1;
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    check_eq("reset_vld_out", W'(vld_out), '0);
    check_eq("reset_data_out", data_out, '0);
    nslices = 0;
    @(posedge clk);
    edge_n++;
    #1 rst = 1'b1;
  endtask

  // Monitor for the main instance: every vld_out pulse must match the head of the queue.
  always @(negedge clk) begin
    logic [W-1:0] w;
    int e;
    if (vld_out) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_vld_out: got pulse with %h at edge %0d, required none", data_out, edge_n);
      end else begin
        w = exp_q.pop_front();
        e = exp_e_q.pop_front();
        check_eq("word_data", data_out, w);
        check_eq("word_edge", W'(edge_n), W'(e));
      end
    end
`ifdef FROM_SERIAL_SYNC_EN
    if (err) begin
      if (err_e_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_err: got pulse at edge %0d, required none", edge_n);
      end else begin
        e = err_e_q.pop_front();
        check_eq("err_edge", W'(edge_n), W'(e));
      end
    end
    if (err_d) err_d_seen = 1'b1;
`endif
  end

  always @(negedge clk) begin
    logic [W-1:0] w;
    int e;
    if (vout_d) begin
      if (exp_d_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL deg_unexpected_vld_out: got pulse with %h, required none", dout_d);
      end else begin
        w = exp_d_q.pop_front();
        e = exp_de_q.pop_front();
        check_eq("deg_word_data", dout_d, w);
        check_eq("deg_word_edge", W'(edge_n), W'(e));
      end
    end
  end

  initial begin
    logic [W-1:0] w;
    #1;
    check_eq("init_vld_out", W'(vld_out), '0);
    check_eq("init_data_out", data_out, '0);
    check_eq("init_deg_data_out", dout_d, '0);
`ifdef FROM_SERIAL_SYNC_EN
    check_eq("init_err", W'(err), '0);
`endif
    idle(2);
    rst = 1'b1;
    idle(2);

    // Basic and gapped reassembly of {0xABCD, 0x1234}.
    send_word(32'hABCD_1234, 0, 1'b0);
    idle(3);
    check_eq("basic_hold", data_out, 32'hABCD_1234);
    send_word(32'hABCD_1234, 3, 1'b0);
    idle(3);
    check_eq("gapped_hold", data_out, 32'hABCD_1234);

    // Back-to-back streaming.
    send_word({16'($urandom), 16'h1234}, 0, 1'b0);
    send_word({16'($urandom), 16'h5678}, 0, 1'b0);
    send_word({16'($urandom), 16'h9ABC}, 0, 1'b0);
    idle(4);
    check_eq("stream_hold_ch0", W'(data_out[0]), W'(16'h9ABC));
    check_eq("stream_hold", data_out, last_word);

    // Reset after two slices of 0x1234, then a fresh word.
    step(1'b1, 8'h54, 1'b0);
    step(1'b1, 8'h63, 1'b0);
    do_reset();
    send_word(32'h1111_5678, 0, 1'b0);
    idle(3);
    check_eq("after_reset_word", data_out, 32'h1111_5678);

`ifdef FROM_SERIAL_SYNC_EN
    step(1'b1, 8'h21, 1'b0);
    step(1'b1, 8'h43, 1'b0);
    send_word(32'hCAFE_BEEF, 1, 1'b1);
    idle(3);
    check_eq("sync_word", data_out, 32'hCAFE_BEEF);
`endif

    // Random slices, gaps and (when present) sync marks.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) != 0)
        step(1'b1, NO_CH*BW_IN'($urandom), ($urandom_range(0, 9) == 0));
      else
        idle(1);
    end
    idle(3);

    // One-slice-per-word instance.
    w = {16'($urandom), 16'h0001};
    step_d(1'b1, w);
    w = {16'($urandom), 16'hFFFF};
    step_d(1'b1, w);
    step_d(1'b0, '0);
    step_d(1'b0, '0);
    check_eq("deg_hold", dout_d, w);

    idle(4);
    check_eq("exp_q_drained", W'(exp_q.size()), '0);
    check_eq("exp_d_q_drained", W'(exp_d_q.size()), '0);
`ifdef FROM_SERIAL_SYNC_EN
    check_eq("err_q_drained", W'(err_e_q.size()), '0);
    check_eq("deg_err_never", W'(err_d_seen), '0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
